neuronal_pipe_chain: RTL and testbench

- Parametrised successor to the single-register neuron data stage.
- A DEPTH-stage elastic pipeline of WIDTH-bit registers with a valid/ready handshake on both ends.
- Supports bubble collapsing, synchronous flush and a live occupancy count.
- Sits between neuron compute units wherever a multi-cycle, backpressure-aware data path is needed.

---
 rtl/neuronal_pipe_chain.sv | 79 +++++++
 tb/tb_neuronal_pipe_chain.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuronal_pipe_chain.sv
// Elastic valid/ready register pipeline with bubble collapse, synchronous flush
// and live occupancy count.
module neuronal_pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] en;
  logic [WIDTH-1:0] d [DEPTH];

  // A stage may advance when it is empty or when everything ahead of it moves.
  always_comb begin
    logic en_acc;
    en     = '0;
    en_acc = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      en_acc = !v[k] || en_acc;
      en[k]  = en_acc;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    logic             v_q;
    logic [WIDTH-1:0] d_q;

    if (k == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = in_data;
    end else begin : g_body
      assign up_v = v[k-1];
      assign up_d = d[k-1];
    end

    // Flush drops valids only; data registers keep their last word.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (flush) begin
        v_q <= 1'b0;
      end else if (en[k]) begin
        v_q <= up_v;
        if (up_v) begin
          d_q <= up_d;
        end
      end
    end

    assign v[k] = v_q;
    assign d[k] = d_q;
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(v[k]);
    end
  end

  assign in_ready  = en[0] && !flush;
  assign out_valid = v[DEPTH-1] && !flush;
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_neuronal_pipe_chain.sv
// Bench for neuronal_pipe_chain: directed vector table on a 32x4 pipe, mid-stream
// reset, then randomized traffic on 32x4 and 8x1 pipes against a word-position model.
module tb_neuronal_pipe_chain;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4, WIDTH=32 instance
  logic        fl4 = 0, iv4 = 0, or4 = 0;
  logic [31:0] id4 = '0;
  logic        ir4, ov4;
  logic [31:0] od4;
  logic [2:0]  oc4;

  // DEPTH=1, WIDTH=8 instance
  logic        fl1 = 0, iv1 = 0, or1 = 0;
  logic [7:0]  id1 = '0;
  logic        ir1, ov1;
  logic [7:0]  od1;
  logic [0:0]  oc1;

  neuronal_pipe_chain #(.WIDTH(32), .DEPTH(4)) u4 (
    .clk(clk), .reset_n(reset_n), .flush(fl4),
    .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .occupancy(oc4)
  );

  neuronal_pipe_chain #(.WIDTH(8), .DEPTH(1)) u1 (
    .clk(clk), .reset_n(reset_n), .flush(fl1),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(oc1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model: list of in-flight words with stage positions
  int          m_depth [2] = '{4, 1};
  int          m_cnt   [2];
  int          m_pos   [2][8];
  logic [31:0] m_dat   [2][8];
  bit          m_mv    [2][8];
  logic [31:0] m_tail  [2];
  bit          m_ir    [2];
  bit          m_ov    [2];

  function automatic void model_reset(int j);
    m_cnt[j]  = 0;
    m_tail[j] = '0;
  endfunction

  // Oldest word advances unless it sits at the tail and downstream stalls;
  // a younger word advances if the slot ahead is free or is being vacated.
  function automatic void model_eval(int j, bit fl, bit ordy);
    int dep = m_depth[j];
    for (int i = 0; i < m_cnt[j]; i++) begin
      if (i == 0) m_mv[j][i] = (m_pos[j][0] == dep - 1) ? ordy : 1'b1;
      else        m_mv[j][i] = (m_pos[j][i] + 1 != m_pos[j][i-1]) || m_mv[j][i-1];
    end
    m_ir[j] = !fl && (m_cnt[j] == 0 || m_pos[j][m_cnt[j]-1] != 0 || m_mv[j][m_cnt[j]-1]);
    m_ov[j] = !fl && m_cnt[j] > 0 && m_pos[j][0] == dep - 1;
  endfunction

  function automatic void model_edge(int j, bit fl, bit iv, logic [31:0] id, bit ordy);
    int          dep = m_depth[j];
    int          n = 0;
    int          np [8];
    logic [31:0] nd [8];
    if (fl) begin
      m_cnt[j] = 0;
      return;
    end
    for (int i = 0; i < m_cnt[j]; i++) begin
      if (i == 0 && m_pos[j][0] == dep - 1 && ordy) continue;
      np[n] = m_mv[j][i] ? m_pos[j][i] + 1 : m_pos[j][i];
      nd[n] = m_dat[j][i];
      if (m_mv[j][i] && np[n] == dep - 1) m_tail[j] = nd[n];
      n++;
    end
    if (iv && m_ir[j]) begin
      np[n] = 0;
      nd[n] = id;
      if (dep == 1) m_tail[j] = id;
      n++;
    end
    for (int i = 0; i < n; i++) begin
      m_pos[j][i] = np[i];
      m_dat[j][i] = nd[i];
    end
    m_cnt[j] = n;
  endfunction

  // ---------------- directed vector table for the DEPTH=4 instance
  typedef struct {
    bit          fl;
    bit          iv;
    logic [31:0] id;
    bit          ordy;
    bit          ir;
    bit          ov;
    logic [31:0] od;
    int          occ;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit fl, bit iv, logic [31:0] id, bit ordy,
                              bit ir, bit ov, logic [31:0] od, int occ);
    vec_t t;
    t.fl = fl; t.iv = iv; t.id = id; t.ordy = ordy;
    t.ir = ir; t.ov = ov; t.od = od; t.occ = occ;
    tbl.push_back(t);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // backpressure: 6 words into a stalled pipe, then drain
    add(0,1,32'h1,0, 1,0,32'h0,0);
    add(0,1,32'h2,0, 1,0,32'h0,1);
    add(0,1,32'h3,0, 1,0,32'h0,2);
    add(0,1,32'h4,0, 1,0,32'h0,3);
    add(0,1,32'h5,0, 0,1,32'h1,4);
    add(0,1,32'h5,1, 1,1,32'h1,4);
    add(0,1,32'h6,1, 1,1,32'h2,4);
    add(0,0,32'h0,1, 1,1,32'h3,4);
    add(0,0,32'h0,1, 1,1,32'h4,3);
    add(0,0,32'h0,1, 1,1,32'h5,2);
    add(0,0,32'h0,1, 1,1,32'h6,1);
    add(0,0,32'h0,1, 1,0,32'h6,0);
    // bubble collapse behind a stall
    add(0,1,32'hA,0, 1,0,32'h6,0);
    add(0,0,32'h0,0, 1,0,32'h6,1);
    add(0,0,32'h0,0, 1,0,32'h6,1);
    add(0,1,32'hB,0, 1,0,32'h6,1);
    add(0,0,32'h0,0, 1,1,32'hA,2);
    add(0,0,32'h0,0, 1,1,32'hA,2);
    add(0,0,32'h0,0, 1,1,32'hA,2);
    add(0,0,32'h0,1, 1,1,32'hA,2);
    add(0,0,32'h0,1, 1,1,32'hB,1);
    add(0,0,32'h0,1, 1,0,32'hB,0);
    // flush with a word presented: nothing captured, data regs hold
    add(0,1,32'h11,0, 1,0,32'hB,0);
    add(0,1,32'h12,0, 1,0,32'hB,1);
    add(0,1,32'h13,0, 1,0,32'hB,2);
    add(1,1,32'h99,1, 0,0,32'hB,3);
    add(0,0,32'h0,1,  1,0,32'hB,0);
    add(0,0,32'h0,1,  1,0,32'hB,0);
    // streaming 1..8 at full rate, latency DEPTH
    add(0,1,32'h1,1, 1,0,32'hB,0);
    add(0,1,32'h2,1, 1,0,32'hB,1);
    add(0,1,32'h3,1, 1,0,32'hB,2);
    add(0,1,32'h4,1, 1,0,32'hB,3);
    add(0,1,32'h5,1, 1,1,32'h1,4);
    add(0,1,32'h6,1, 1,1,32'h2,4);
    add(0,1,32'h7,1, 1,1,32'h3,4);
    add(0,1,32'h8,1, 1,1,32'h4,4);
    add(0,0,32'h0,1, 1,1,32'h5,4);
    add(0,0,32'h0,1, 1,1,32'h6,3);
    add(0,0,32'h0,1, 1,1,32'h7,2);
    add(0,0,32'h0,1, 1,1,32'h8,1);
    add(0,0,32'h0,1, 1,0,32'h8,0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready4",  0, 32'(ir4), 32'd1);
    chk("rst_out_valid4", 0, 32'(ov4), 32'd0);
    chk("rst_out_data4",  0, od4,      32'd0);
    chk("rst_occ4",       0, 32'(oc4), 32'd0);
    chk("rst_out_valid1", 0, 32'(ov1), 32'd0);
    chk("rst_occ1",       0, 32'(oc1), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      fl4 = tbl[i].fl; iv4 = tbl[i].iv; id4 = tbl[i].id; or4 = tbl[i].ordy;
      #1;
      chk("tbl_in_ready",  i, 32'(ir4), 32'(tbl[i].ir));
      chk("tbl_out_valid", i, 32'(ov4), 32'(tbl[i].ov));
      chk("tbl_out_data",  i, od4,      tbl[i].od);
      chk("tbl_occupancy", i, 32'(oc4), 32'(tbl[i].occ));
    end

    // reset pulse mid-stream with four words in flight
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      fl4 = 0; iv4 = 1; id4 = 32'h21 + 32'(i); or4 = 0;
    end
    @(negedge clk);
    iv4 = 0;
    #1;
    chk("pre_rst_occ", 0, 32'(oc4), 32'd4);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 0, 32'(ov4), 32'd0);
    chk("midrst_out_data",  0, od4,      32'd0);
    chk("midrst_occ",       0, 32'(oc4), 32'd0);
    chk("midrst_in_ready",  0, 32'(ir4), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    or4 = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("postrst_out_valid", i, 32'(ov4), 32'd0);
      chk("postrst_occ",       i, 32'(oc4), 32'd0);
    end

    // randomized traffic on both instances against the model
    @(negedge clk);
    reset_n = 1'b0;
    fl4 = 0; iv4 = 0; or4 = 0; fl1 = 0; iv1 = 0; or1 = 0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset(0);
    model_reset(1);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      fl4 = ($urandom_range(0, 19) == 0);
      iv4 = $urandom_range(0, 1);
      id4 = $urandom;
      or4 = $urandom_range(0, 1);
      fl1 = ($urandom_range(0, 19) == 0);
      iv1 = $urandom_range(0, 1);
      id1 = 8'($urandom);
      or1 = $urandom_range(0, 1);
      model_eval(0, fl4, or4);
      model_eval(1, fl1, or1);
      #1;
      chk("rnd4_in_ready",  c, 32'(ir4), 32'(m_ir[0]));
      chk("rnd4_out_valid", c, 32'(ov4), 32'(m_ov[0]));
      chk("rnd4_out_data",  c, od4,      m_tail[0]);
      chk("rnd4_occupancy", c, 32'(oc4), 32'(m_cnt[0]));
      chk("rnd1_in_ready",  c, 32'(ir1), 32'(m_ir[1]));
      chk("rnd1_out_valid", c, 32'(ov1), 32'(m_ov[1]));
      chk("rnd1_out_data",  c, 32'(od1), m_tail[1]);
      chk("rnd1_occupancy", c, 32'(oc1), 32'(m_cnt[1]));
      @(posedge clk);
      model_edge(0, fl4, iv4, id4, or4);
      model_edge(1, fl1, iv1, 32'(id1), or1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
